serial_tx_param: RTL and testbench
==================================

Name: serial_tx_param

Overview:
Parametrised synchronous serial frame transmitter, the successor to the team's fixed 8-bit one-bit-per-clock transmitter.
- Serialises a DATA_W-bit word, LSB first.
- Frame: start bit, data bits, optional parity bit, 1 or 2 stop bits.
- Each bit is held for CLKS_PER_BIT clocks.
- Replaces the edge-triggered send with a valid/ready handshake, adds a completion pulse, and sits between a byte producer and the board TX pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..16
CLKS_PER_BIT, 1, clocks each line bit is held; must be >= 1
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2
START_LEVEL, 1, line level of the start bit; idle and stop level is ~START_LEVEL

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
tx_valid  input  1  producer offers tx_data
tx_data  input  DATA_W  word to send; sampled only on acceptance
tx_ready  output  1  block can accept a word this cycle
txd  output  1  serial line, registered
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values: txd=~START_LEVEL, tx_ready=0 while rst is high, busy=0, done=0. State=IDLE; bit counter, divider counter and shift register all cleared.
- tx_ready = (state==IDLE) && !rst. Acceptance = tx_valid && tx_ready at a clk edge. On acceptance, tx_data is latched into the shift register.
- Latency: the start bit appears on txd in the cycle after the acceptance edge.
- States and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA.
  - DATA -> PARITY or STOP after DATA_W bits.
  - PARITY -> STOP.
  - STOP -> IDLE after STOP_BITS bits.
- Bit timing: every state except IDLE lasts exactly CLKS_PER_BIT clocks per bit. A divider counter runs 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
- Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from the first start-bit cycle.
- Line levels per state:
  - START: START_LEVEL.
  - DATA: bit i = tx_data[i], i from 0 to DATA_W-1.
  - PARITY: XOR of the latched data, inverted when PARITY_ODD=1.
  - STOP and IDLE: ~START_LEVEL.
- done: high for exactly one cycle, namely the first IDLE cycle after the last stop-bit cycle. busy is low in that same cycle.
- Minimum inter-frame gap is one IDLE cycle. With tx_valid held high, the next start bit begins 1 cycle after done.
- tx_valid and tx_data changes while busy are ignored. The latched word is immune to them.
- Reset mid-frame: on the next edge txd returns to idle level, the frame is discarded, done does not pulse, and no partial bits are emitted afterwards.
- Simultaneous rst and tx_valid: rst wins; the word is not accepted.
- Counter widths: $clog2 of their maximum value, minimum 1 bit. CLKS_PER_BIT=1 must work with no idle stretching.

Decomposition:
- Package serial_tx_pkg holds:
  - state encoding localparams S_IDLE, S_START, S_DATA, S_PARITY, S_STOP;
  - function frame_cycles(DATA_W, PARITY_EN, STOP_BITS, CLKS_PER_BIT) for benches.
- One sub-module: serial_tx_baud.
  - Function: bit-period divider.
  - Inputs: clk, rst, run.
  - Output: bit_tick, asserted on the last clock of each bit period.
  - Counter clears whenever run=0.

Test Plan:
1. Defaults, accept 0xA5 -> txd after acceptance = 1, 1,0,1,0,0,1,0,1, 0, then idle 0. done pulses in cycle 11 after the acceptance edge; frame is 10 cycles.
2. PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit 1. Same with PARITY_ODD=1 -> parity bit 0. Frame is 11 cycles.
3. CLKS_PER_BIT=4, STOP_BITS=2, data 0x3C -> every bit held exactly 4 cycles. Frame is 44 cycles; busy is high for 44 cycles; tx_ready is low throughout.
4. tx_valid held high with 0x55 then 0xAA -> both frames sent intact with exactly one idle cycle between them. Changing tx_data mid-frame does not alter the frame in flight.
5. rst asserted during data bit 3 of 0xFF -> txd=0 on the next edge, busy=0, no done pulse. A following 0x01 is sent correctly.
6. START_LEVEL=0, DATA_W=5, data 0x13 -> idle 1, start 0, bits 1,1,0,0,1, stop 1.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the parametrised serial frame transmitter:
// state encoding, counter sizing and frame-length helper.
package serial_tx_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } tx_state_e;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits,
                                               input int unsigned clks_per_bit);
    return (32'd1 + data_w + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_tx_baud.sv
// Bit-period divider: bit_tick marks the last clock of each line bit.
// The counter is held at zero whenever run is low.
module serial_tx_baud
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter, wraps on terminal count
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bit_tick = run && (cnt_r == CNT_LAST);

endmodule

// File: rtl/serial_tx_param.sv
// Parametrised serial frame transmitter: valid/ready input, LSB-first data,
// optional parity, 1 or 2 stop bits, registered line output.
module serial_tx_param
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic        START_LEVEL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam logic              IDLE_LEVEL = ~START_LEVEL;
  localparam logic              PAR_ODD    = (PARITY_ODD != 32'd0) ? 1'b1 : 1'b0;
  localparam int unsigned       BCNT_W     = cnt_width(DATA_W);
  localparam logic [BCNT_W-1:0] DATA_LAST  = BCNT_W'(DATA_W - 32'd1);
  localparam logic [BCNT_W-1:0] STOP_LAST  = BCNT_W'(STOP_BITS - 32'd1);
  localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(32'd1);

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  tx_state_e         state_r, state_nxt_s;
  logic [BCNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic              par_r, par_nxt_s;
  logic              txd_r, txd_nxt_s;
  logic              done_r, done_nxt_s;
  logic              run_s, bit_tick_s, accept_s;

  assign tx_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s = tx_valid && tx_ready;
  assign run_s    = (state_r != ST_IDLE);
  assign busy     = run_s;
  assign txd      = txd_r;
  assign done     = done_r;

  serial_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .bit_tick(bit_tick_s)
  );

  // Next-state, counters and latched word
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    par_nxt_s     = par_r;
    done_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s   = ST_START;
          bit_cnt_nxt_s = '0;
          shift_nxt_s   = tx_data;
          par_nxt_s     = calc_parity(tx_data);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          state_nxt_s   = ST_DATA;
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_nxt_s = '0;
            if (PARITY_EN != 32'd0) begin
              state_nxt_s = ST_PARITY;
            end else begin
              state_nxt_s = ST_STOP;
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BCNT_ONE;
            shift_nxt_s   = {1'b0, shift_r[DATA_W-1:1]};
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_tick_s) begin
          state_nxt_s   = ST_STOP;
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = '0;
            done_nxt_s    = 1'b1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BCNT_ONE;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so txd can be registered
  // without adding a cycle of latency.
  always_comb begin
    txd_nxt_s = IDLE_LEVEL;
    case (state_nxt_s)
      ST_START:  txd_nxt_s = START_LEVEL;
      ST_DATA:   txd_nxt_s = shift_nxt_s[0];
      ST_PARITY: txd_nxt_s = par_nxt_s;
      default:   txd_nxt_s = IDLE_LEVEL;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      txd_r     <= IDLE_LEVEL;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      par_r     <= par_nxt_s;
      txd_r     <= txd_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_serial_tx_param.sv
// Directed bench for serial_tx_param: five parameter sets, each frame
// checked bit-by-bit against hand-written line patterns.
module tb_serial_tx_param;

  logic        clk;
  logic        rst;
  logic        valid_s [5];
  logic [15:0] data_s  [5];
  logic        ready_s [5];
  logic        txd_s   [5];
  logic        busy_s  [5];
  logic        done_s  [5];

  int err_cnt = 0;
  int chk_cnt = 0;

  // u0 defaults, u1 even parity, u2 odd parity, u3 slow + 2 stop, u4 low start 5-bit
  serial_tx_param u0 (
    .clk(clk), .rst(rst), .tx_valid(valid_s[0]), .tx_data(data_s[0][7:0]),
    .tx_ready(ready_s[0]), .txd(txd_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  serial_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .tx_valid(valid_s[1]), .tx_data(data_s[1][7:0]),
    .tx_ready(ready_s[1]), .txd(txd_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  serial_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(valid_s[2]), .tx_data(data_s[2][7:0]),
    .tx_ready(ready_s[2]), .txd(txd_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  serial_tx_param #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(valid_s[3]), .tx_data(data_s[3][7:0]),
    .tx_ready(ready_s[3]), .txd(txd_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  serial_tx_param #(.START_LEVEL(1'b0), .DATA_W(5)) u4 (
    .clk(clk), .rst(rst), .tx_valid(valid_s[4]), .tx_data(data_s[4][4:0]),
    .tx_ready(ready_s[4]), .txd(txd_s[4]), .busy(busy_s[4]), .done(done_s[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single cycle, then scramble the input to prove it is latched.
  task automatic send(input int sel, input logic [15:0] w);
    check($sformatf("u%0d ready before send", sel), {31'd0, ready_s[sel]}, 32'd1);
    valid_s[sel] = 1'b1;
    data_s[sel]  = w;
    tick();
    valid_s[sel] = 1'b0;
    data_s[sel]  = ~w;
  endtask

  // Starts in the first start-bit cycle; ends in the done cycle.
  task automatic check_frame(input int sel, input string tag, input string bits,
                             input int cpb, input logic idle);
    for (int b = 0; b < bits.len(); b++) begin
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("%s txd b%0d c%0d", tag, b, c), {31'd0, txd_s[sel]},
              (bits[b] == 8'h31) ? 32'd1 : 32'd0);
        check($sformatf("%s busy b%0d c%0d", tag, b, c), {31'd0, busy_s[sel]}, 32'd1);
        check($sformatf("%s ready b%0d c%0d", tag, b, c), {31'd0, ready_s[sel]}, 32'd0);
        check($sformatf("%s done b%0d c%0d", tag, b, c), {31'd0, done_s[sel]}, 32'd0);
        tick();
      end
    end
    check($sformatf("%s done pulse", tag), {31'd0, done_s[sel]}, 32'd1);
    check($sformatf("%s busy at done", tag), {31'd0, busy_s[sel]}, 32'd0);
    check($sformatf("%s txd at done", tag), {31'd0, txd_s[sel]}, {31'd0, idle});
    check($sformatf("%s ready at done", tag), {31'd0, ready_s[sel]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_s[i] = 1'b0;
      data_s[i]  = 16'h0000;
    end
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("u%0d reset txd", i), {31'd0, txd_s[i]}, (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("u%0d reset ready", i), {31'd0, ready_s[i]}, 32'd0);
      check($sformatf("u%0d reset busy", i), {31'd0, busy_s[i]}, 32'd0);
      check($sformatf("u%0d reset done", i), {31'd0, done_s[i]}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("u0 ready after reset", {31'd0, ready_s[0]}, 32'd1);

    // rst and tx_valid together: word must not be accepted
    rst = 1'b1;
    valid_s[0] = 1'b1;
    data_s[0]  = 16'h00A5;
    tick();
    rst = 1'b0;
    valid_s[0] = 1'b0;
    tick();
    check("rst+valid busy", {31'd0, busy_s[0]}, 32'd0);
    check("rst+valid txd", {31'd0, txd_s[0]}, 32'd0);

    // 1: defaults, 0xA5
    send(0, 16'h00A5);
    check_frame(0, "t1", "1101001010", 1, 1'b0);
    tick();
    check("t1 done one cycle", {31'd0, done_s[0]}, 32'd0);

    // 2: parity even / odd on 0x07
    send(1, 16'h0007);
    check_frame(1, "t2even", "11110000010", 1, 1'b0);
    send(2, 16'h0007);
    check_frame(2, "t2odd", "11110000000", 1, 1'b0);

    // 3: 4 clocks per bit, two stop bits, 0x3C
    send(3, 16'h003C);
    check_frame(3, "t3", "10011110000", 4, 1'b0);

    // 4: back-to-back with valid held, data changed mid-frame
    valid_s[0] = 1'b1;
    data_s[0]  = 16'h0055;
    tick();
    data_s[0]  = 16'h00AA;
    check_frame(0, "t4a", "1101010100", 1, 1'b0);
    tick();
    valid_s[0] = 1'b0;
    data_s[0]  = 16'h003C;
    check_frame(0, "t4b", "1010101010", 1, 1'b0);

    // 5: reset during data bit 3 of 0xFF, then 0x01
    tick();
    send(0, 16'h00FF);
    repeat (4) tick();
    check("t5 bit3 level", {31'd0, txd_s[0]}, 32'd1);
    rst = 1'b1;
    tick();
    check("t5 txd after rst", {31'd0, txd_s[0]}, 32'd0);
    check("t5 busy after rst", {31'd0, busy_s[0]}, 32'd0);
    check("t5 done after rst", {31'd0, done_s[0]}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("t5 quiet txd %0d", k), {31'd0, txd_s[0]}, 32'd0);
      check($sformatf("t5 quiet done %0d", k), {31'd0, done_s[0]}, 32'd0);
      check($sformatf("t5 quiet busy %0d", k), {31'd0, busy_s[0]}, 32'd0);
    end
    send(0, 16'h0001);
    check_frame(0, "t5b", "1100000000", 1, 1'b0);

    // 6: start level 0, 5 data bits, 0x13
    check("t6 idle level", {31'd0, txd_s[4]}, 32'd1);
    send(4, 16'h0013);
    check_frame(4, "t6", "0110011", 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
